// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N raw push-buttons with a single shared timer.
// A round-robin scan hands the timer to the next button whose synchronized
// level differs from its debounced level. The change is committed only after
// the new level has held for DEBOUNCE_TIME cycles. A commit raises a
// one-cycle pressed/released pulse and records the button index in code.
module debounce_scheduler #(
  parameter int N             = 4,
  parameter int DEBOUNCE_TIME = 50000,
  localparam int CW           = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  buttons,
  input  logic          enable,
  output logic [N-1:0]  stable,
  output logic          pressed,
  output logic          released,
  output logic [CW-1:0] code,
  output logic          busy
);

  localparam int TW = ($clog2(DEBOUNCE_TIME) > 1) ? $clog2(DEBOUNCE_TIME) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(DEBOUNCE_TIME - 1);

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  sync_meta_q;
  logic [N-1:0]  sync_q;
  logic [N-1:0]  stable_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] owner_q;
  logic [CW-1:0] code_q;
  logic [TW-1:0] timer_q;
  logic          pressed_q;
  logic          released_q;
  logic [CW-1:0] idx_inc_d;
  logic [CW-1:0] owner_inc_d;

  // Wrapping successors of the scan pointer and of the timer owner.
  assign idx_inc_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign owner_inc_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Two-flop synchronizer; all later decisions use sync_q only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= buttons;
      sync_q      <= sync_meta_q;
    end
  end

  // Scan / count / commit sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      idx_q      <= '0;
      owner_q    <= '0;
      timer_q    <= '0;
      stable_q   <= '0;
      code_q     <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (enable) begin
            if (sync_q[idx_q] != stable_q[idx_q]) begin
              owner_q <= idx_q;
              timer_q <= '0;
              state_q <= COUNT;
            end else begin
              idx_q <= idx_inc_d;
            end
          end
        end
        COUNT: begin
          if (!enable) begin
            // Leave the pointer on the owner so it is rechecked first.
            idx_q   <= owner_q;
            state_q <= SCAN;
          end else if (sync_q[owner_q] == stable_q[owner_q]) begin
            // Input reverted: a bounce. Move on so others are not starved.
            idx_q   <= owner_inc_d;
            state_q <= SCAN;
          end else if (timer_q == TIMER_END) begin
            stable_q[owner_q] <= ~stable_q[owner_q];
            code_q            <= owner_q;
            pressed_q         <= ~stable_q[owner_q];
            released_q        <= stable_q[owner_q];
            state_q           <= COMMIT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        COMMIT: begin
          idx_q   <= owner_inc_d;
          state_q <= SCAN;
        end
        default: begin
          state_q <= SCAN;
        end
      endcase
    end
  end

  assign stable   = stable_q;
  assign pressed  = pressed_q;
  assign released = released_q;
  assign code     = code_q;
  assign busy     = (state_q != SCAN);

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios with timing derived from
// the commit-latency rules, then randomized bouncing inputs checked cycle by
// cycle against an event-level reference model.
module tb_debounce_scheduler;
  localparam int N  = 4;
  localparam int DT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] buttons = '0;
  logic         enable = 1'b0;
  logic [N-1:0] stable;
  logic         pressed;
  logic         released;
  logic [1:0]   code;
  logic         busy;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers, one entry per button).
  int m_s1[N];
  int m_s2[N];
  int m_st[N];
  int m_owner;
  int m_hold;
  int m_ptr;
  int m_code;
  int m_pp;
  int m_pr;

  debounce_scheduler #(.N(N), .DEBOUNCE_TIME(DT)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .enable(enable),
    .stable(stable), .pressed(pressed), .released(released),
    .code(code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    buttons = '0;
    enable  = 1'b0;
    rst_n   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0;
    end
    m_owner = -1; m_hold = 0; m_ptr = 0; m_code = 0; m_pp = 0; m_pr = 0;
  endtask

  // Predicts the outputs after the next clock edge given the inputs
  // presented during the current cycle. owner = -1 means no button holds
  // the timer; hold counts the cycles the owner's new level has survived.
  task automatic model_step(input logic [N-1:0] raw, input logic en);
    int o;
    if (m_pp != 0 || m_pr != 0) begin
      m_pp = 0; m_pr = 0;
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end else if (m_owner < 0) begin
      if (en) begin
        if (m_s2[m_ptr] != m_st[m_ptr]) begin
          m_owner = m_ptr; m_hold = 0;
        end else begin
          m_ptr = (m_ptr + 1) % N;
        end
      end
    end else begin
      o = m_owner;
      if (!en) begin
        m_ptr = o; m_owner = -1;
      end else if (m_s2[o] == m_st[o]) begin
        m_ptr = (o + 1) % N; m_owner = -1;
      end else begin
        m_hold = m_hold + 1;
        if (m_hold == DT) begin
          m_st[o] = 1 - m_st[o];
          m_code = o;
          m_pp = m_st[o];
          m_pr = 1 - m_st[o];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i] ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; buttons = '0; enable = 1'b0;
    tick(2);
    checks++; if (stable !== 4'b0000) begin failures++; $display("FAIL reset_stable got=%b exp=0000", stable); end
    checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL reset_pressed got=%b exp=0", pressed); end
    checks++; if (released !== 1'b0) begin failures++; $display("FAIL reset_released got=%b exp=0", released); end
    checks++; if (code !== 2'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1; enable = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0 || stable !== 4'b0000) begin failures++; $display("FAIL reset_idle got busy=%b stable=%b exp busy=0 stable=0000", busy, stable); end
  endtask

  // idx=0 with enable low; enable scans 0,1 then detects button 2 (3rd edge).
  task automatic test_clean_press();
    logic [N-1:0] e_st;
    logic e_b, e_p;
    logic [1:0] e_c;
    reset_dut();
    buttons = 4'b0100;
    tick(3);
    enable = 1'b1;
    for (int k = 1; k <= DT + 5; k++) begin
      tick(1);
      e_b  = (k >= 3 && k <= 3 + DT);
      e_p  = (k == 3 + DT);
      e_st = (k >= 3 + DT) ? 4'b0100 : 4'b0000;
      e_c  = (k >= 3 + DT) ? 2'd2 : 2'd0;
      checks++; if (busy !== e_b) begin failures++; $display("FAIL press_busy k=%0d got=%b exp=%b", k, busy, e_b); end
      checks++; if (pressed !== e_p) begin failures++; $display("FAIL press_pulse k=%0d got=%b exp=%b", k, pressed, e_p); end
      checks++; if (released !== 1'b0) begin failures++; $display("FAIL press_released k=%0d got=%b exp=0", k, released); end
      checks++; if (stable !== e_st) begin failures++; $display("FAIL press_stable k=%0d got=%b exp=%b", k, stable, e_st); end
      checks++; if (code !== e_c) begin failures++; $display("FAIL press_code k=%0d got=%0d exp=%0d", k, code, e_c); end
      if (pressed) $display("txn press code=%0d stable=%b", code, stable);
      if (k == 3 + DT) enable = 1'b0;
    end
  endtask

  // Pointer parked at 3: scan 3,0,1 then detect button 2 (4th edge).
  task automatic test_release();
    logic [N-1:0] e_st;
    logic e_b, e_r;
    buttons = 4'b0000;
    tick(3);
    enable = 1'b1;
    for (int k = 1; k <= DT + 6; k++) begin
      tick(1);
      e_b  = (k >= 4 && k <= 4 + DT);
      e_r  = (k == 4 + DT);
      e_st = (k >= 4 + DT) ? 4'b0000 : 4'b0100;
      checks++; if (busy !== e_b) begin failures++; $display("FAIL release_busy k=%0d got=%b exp=%b", k, busy, e_b); end
      checks++; if (released !== e_r) begin failures++; $display("FAIL release_pulse k=%0d got=%b exp=%b", k, released, e_r); end
      checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL release_pressed k=%0d got=%b exp=0", k, pressed); end
      checks++; if (stable !== e_st) begin failures++; $display("FAIL release_stable k=%0d got=%b exp=%b", k, stable, e_st); end
      checks++; if (code !== 2'd2) begin failures++; $display("FAIL release_code k=%0d got=%0d exp=2", k, code); end
      if (released) $display("txn release code=%0d stable=%b", code, stable);
      if (k == 4 + DT) enable = 1'b0;
    end
  endtask

  // Button 1 high for 5 edges; sync high edges 2..6, detect at 3, abort at 8.
  task automatic test_glitch();
    logic e_b;
    buttons[1] = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      e_b = (k >= 3 && k <= 7);
      checks++; if (busy !== e_b) begin failures++; $display("FAIL glitch_busy k=%0d got=%b exp=%b", k, busy, e_b); end
      checks++; if (pressed !== 1'b0 || released !== 1'b0) begin failures++; $display("FAIL glitch_pulse k=%0d got=%b%b exp=00", k, pressed, released); end
      checks++; if (stable !== 4'b0000) begin failures++; $display("FAIL glitch_stable k=%0d got=%b exp=0000", k, stable); end
      if (k == 5) buttons[1] = 1'b0;
    end
    $display("txn glitch on button 1 rejected");
    enable = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] e_st;
    logic e_b, e_p;
    logic [1:0] e_c;
    reset_dut();
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    buttons = 4'b1001;
    tick(3);
    enable = 1'b1;
    for (int k = 1; k <= 2 * DT + 5; k++) begin
      tick(1);
      e_b  = (k >= 1 && k <= 1 + DT) || (k >= 3 + DT && k <= 3 + 2 * DT);
      e_p  = (k == 1 + DT) || (k == 3 + 2 * DT);
      e_st = (k < 1 + DT) ? 4'b0000 : ((k < 3 + 2 * DT) ? 4'b1000 : 4'b1001);
      e_c  = (k >= 1 + DT && k < 3 + 2 * DT) ? 2'd3 : 2'd0;
      checks++; if (busy !== e_b) begin failures++; $display("FAIL simul_busy k=%0d got=%b exp=%b", k, busy, e_b); end
      checks++; if (pressed !== e_p) begin failures++; $display("FAIL simul_pulse k=%0d got=%b exp=%b", k, pressed, e_p); end
      checks++; if (stable !== e_st) begin failures++; $display("FAIL simul_stable k=%0d got=%b exp=%b", k, stable, e_st); end
      checks++; if (code !== e_c) begin failures++; $display("FAIL simul_code k=%0d got=%0d exp=%0d", k, code, e_c); end
      if (pressed) $display("txn press code=%0d stable=%b", code, stable);
      if (k == 3 + 2 * DT) enable = 1'b0;
    end
  endtask

  // Pointer parked at 1 after the previous commit of button 0.
  task automatic test_enable_drop();
    logic [N-1:0] e_st;
    logic e_p;
    buttons = 4'b1011;
    tick(3);
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      checks++; if (busy !== (k <= 4)) begin failures++; $display("FAIL endrop_busy k=%0d got=%b exp=%b", k, busy, (k <= 4)); end
      checks++; if (pressed !== 1'b0 || stable !== 4'b1001) begin failures++; $display("FAIL endrop_abort k=%0d got p=%b st=%b exp p=0 st=1001", k, pressed, stable); end
      if (k == 4) enable = 1'b0;
    end
    enable = 1'b1;
    for (int k = 1; k <= DT + 3; k++) begin
      tick(1);
      e_p  = (k == 1 + DT);
      e_st = (k >= 1 + DT) ? 4'b1011 : 4'b1001;
      checks++; if (busy !== (k <= 1 + DT)) begin failures++; $display("FAIL endrop_rebusy k=%0d got=%b exp=%b", k, busy, (k <= 1 + DT)); end
      checks++; if (pressed !== e_p) begin failures++; $display("FAIL endrop_pulse k=%0d got=%b exp=%b", k, pressed, e_p); end
      checks++; if (stable !== e_st) begin failures++; $display("FAIL endrop_stable k=%0d got=%b exp=%b", k, stable, e_st); end
      if (pressed) begin
        checks++; if (code !== 2'd1) begin failures++; $display("FAIL endrop_code got=%0d exp=1", code); end
        $display("txn press code=%0d stable=%b", code, stable);
      end
      if (k == 1 + DT) enable = 1'b0;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [N-1:0] e_st;
    logic e_b, e_p;
    reset_dut();
    buttons = 4'b0100;
    tick(3);
    enable = 1'b1;
    tick(3 + 5);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (stable !== 4'b0000 || busy !== 1'b0 || pressed !== 1'b0 || released !== 1'b0 || code !== 2'd0)
      begin failures++; $display("FAIL midreset_outputs got st=%b busy=%b p=%b r=%b code=%0d exp all 0", stable, busy, pressed, released, code); end
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= DT + 5; k++) begin
      tick(1);
      e_b  = (k >= 3 && k <= 3 + DT);
      e_p  = (k == 3 + DT);
      e_st = (k >= 3 + DT) ? 4'b0100 : 4'b0000;
      checks++; if (busy !== e_b) begin failures++; $display("FAIL midreset_busy k=%0d got=%b exp=%b", k, busy, e_b); end
      checks++; if (pressed !== e_p) begin failures++; $display("FAIL midreset_pulse k=%0d got=%b exp=%b", k, pressed, e_p); end
      checks++; if (stable !== e_st) begin failures++; $display("FAIL midreset_stable k=%0d got=%b exp=%b", k, stable, e_st); end
      if (pressed) $display("txn press code=%0d stable=%b", code, stable);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] e_st;
    reset_dut();
    model_init();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) buttons[i] = ~buttons[i];
      if (enable) begin
        if ($urandom_range(0, 59) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
      model_step(buttons, enable);
      tick(1);
      for (int i = 0; i < N; i++) e_st[i] = (m_st[i] != 0);
      checks++; if (stable !== e_st) begin failures++; $display("FAIL rand_stable cyc=%0d got=%b exp=%b", cyc, stable, e_st); end
      checks++; if (busy !== (m_owner >= 0)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, (m_owner >= 0)); end
      checks++; if (pressed !== (m_pp != 0)) begin failures++; $display("FAIL rand_pressed cyc=%0d got=%b exp=%b", cyc, pressed, (m_pp != 0)); end
      checks++; if (released !== (m_pr != 0)) begin failures++; $display("FAIL rand_released cyc=%0d got=%b exp=%b", cyc, released, (m_pr != 0)); end
      checks++; if (code !== 2'(m_code)) begin failures++; $display("FAIL rand_code cyc=%0d got=%0d exp=%0d", cyc, code, m_code); end
      if (pressed || released) $display("txn cyc=%0d %s code=%0d stable=%b", cyc, pressed ? "press" : "release", code, stable);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_simultaneous();
    test_enable_drop();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
